// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU logic scheduler: opcode and FSM state enums,
// plus the statistics counter width.
package alu_sched_pkg;

  typedef enum logic [2:0] {
    OP_NOT  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/alu_logic_unit.sv
// Purely combinational 16-bit bitwise logic unit shared by all requesters.
module alu_logic_unit
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r
);

  // opcode decode; b is unused by NOT and PASS
  always_comb begin
    r = a;
    case (op)
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_PASS: r = a;
      default: r = a;
    endcase
  end

endmodule

// File: rtl/alu_logic_scheduler.sv
// Round-robin scheduler sharing one logic unit between NREQ requesters.
// Optional per-requester completion counters: define ALU_SCHED_STATS_EN.
module alu_logic_scheduler
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [3*NREQ-1:0]        req_op,
  input  logic [WIDTH*NREQ-1:0]    req_a,
  input  logic [WIDTH*NREQ-1:0]    req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [2:0]               rsp_id,
  output logic                     rsp_zero,
  output logic [STAT_W*NREQ-1:0]   stat_count
);

  state_e           state_r;
  logic [2:0]       rr_ptr_r;
  logic [2:0]       id_r;
  op_e              op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  logic             gnt_found_s;
  logic [2:0]       gnt_id_s;
  logic [3:0]       cand_s;
  logic [2:0]       sel_op_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic [WIDTH-1:0] r_s;
  logic             fire_s;

  assign fire_s = rsp_valid && rsp_ready;

  // round-robin search: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_id_s    = 3'd0;
    cand_s      = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, rr_ptr_r} + 4'(k);
      cand_s = (cand_s >= 4'(NREQ)) ? (cand_s - 4'(NREQ)) : cand_s;
      for (int j = 0; j < NREQ; j++) begin
        gnt_id_s    = (!gnt_found_s && req_valid[j] && (cand_s == 4'(j))) ? 3'(j) : gnt_id_s;
        gnt_found_s = gnt_found_s | (req_valid[j] && (cand_s == 4'(j)));
      end
    end
  end

  // operand mux for the granted requester
  always_comb begin
    sel_op_s = 3'd0;
    sel_a_s  = {WIDTH{1'b0}};
    sel_b_s  = {WIDTH{1'b0}};
    for (int j = 0; j < NREQ; j++) begin
      sel_op_s = (gnt_id_s == 3'(j)) ? req_op[3*j +: 3]         : sel_op_s;
      sel_a_s  = (gnt_id_s == 3'(j)) ? req_a[WIDTH*j +: WIDTH]  : sel_a_s;
      sel_b_s  = (gnt_id_s == 3'(j)) ? req_b[WIDTH*j +: WIDTH]  : sel_b_s;
    end
  end

  // accept strobe is combinational so the handshake completes in IDLE
  always_comb begin
    for (int j = 0; j < NREQ; j++) begin
      req_ready[j] = (state_r == ST_IDLE) && gnt_found_s && (gnt_id_s == 3'(j));
    end
  end

  alu_logic_unit #(.WIDTH(WIDTH)) u_lu (
    .op (op_r),
    .a  (a_r),
    .b  (b_r),
    .r  (r_s)
  );

  // sequencer FSM: IDLE accept -> EXEC compute -> RESP hold until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      rr_ptr_r  <= 3'd0;
      id_r      <= 3'd0;
      op_r      <= OP_NOT;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      rsp_valid <= 1'b0;
      rsp_data  <= {WIDTH{1'b0}};
      rsp_id    <= 3'd0;
      rsp_zero  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (gnt_found_s) begin
            op_r    <= op_e'(sel_op_s);
            a_r     <= sel_a_s;
            b_r     <= sel_b_s;
            id_r    <= gnt_id_s;
            state_r <= ST_EXEC;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          rsp_data  <= r_s;
          rsp_id    <= id_r;
          rsp_zero  <= (r_s == {WIDTH{1'b0}});
          rsp_valid <= 1'b1;
          state_r   <= ST_RESP;
        end
        ST_RESP: begin
          if (fire_s) begin
            rsp_valid <= 1'b0;
            // pointer moves only on completion, never on grant
            rr_ptr_r  <= (id_r == 3'(NREQ-1)) ? 3'd0 : (id_r + 3'd1);
            state_r   <= ST_IDLE;
          end else begin
            state_r   <= ST_RESP;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SCHED_STATS_EN
  logic [STAT_W-1:0] cnt_r [NREQ];

  // saturating per-requester completion counters
  always_ff @(posedge clk) begin
    for (int j = 0; j < NREQ; j++) begin
      if (rst) begin
        cnt_r[j] <= {STAT_W{1'b0}};
      end else if (fire_s && (rsp_id == 3'(j)) && (cnt_r[j] != {STAT_W{1'b1}})) begin
        cnt_r[j] <= cnt_r[j] + STAT_W'(1);
      end else begin
        cnt_r[j] <= cnt_r[j];
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_count[STAT_W*g +: STAT_W] = cnt_r[g];
  end
`else
  assign stat_count = {(STAT_W*NREQ){1'b0}};
`endif

endmodule

// File: tb/tb_alu_logic_scheduler.sv
// Self-checking bench for alu_logic_scheduler: directed steps followed by
// randomized traffic against a transaction-level reference model.
module tb_alu_logic_scheduler;

  localparam int NREQ = 2;
  localparam int W    = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [3*NREQ-1:0]   req_op;
  logic [W*NREQ-1:0]   req_a;
  logic [W*NREQ-1:0]   req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [W-1:0]        rsp_data;
  logic [2:0]          rsp_id;
  logic                rsp_zero;
  logic [16*NREQ-1:0]  stat_count;

  alu_logic_scheduler #(.WIDTH(W), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_zero(rsp_zero), .stat_count(stat_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // requester-side view and reference model state
  logic          pend [NREQ];
  logic [2:0]    p_op [NREQ];
  logic [W-1:0]  p_a  [NREQ];
  logic [W-1:0]  p_b  [NREQ];
  int            m_ptr;
  int            m_cnt [NREQ];
  int            m_phase;     // 0 idle, 1 computing, 2 result presented
  int            m_id;
  logic [W-1:0]  m_res;
  int            acc_cyc [$];
  int            acc_id  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int id);
    return NREQ'(1) << id;
  endfunction

  task automatic apply_pins();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = pend[i];
      req_op[3*i +: 3]    = p_op[i];
      req_a[W*i +: W]     = p_a[i];
      req_b[W*i +: W]     = p_b[i];
    end
  endtask

  // one transaction from a single requester with 'hold' cycles of back-pressure
  task automatic do_op(input int id, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input int hold,
                       input string tag);
    int guard;
    pend[id] = 1'b1; p_op[id] = op; p_a[id] = a; p_b[id] = b;
    rsp_ready = 1'b0;
    apply_pins();
    #1;
    guard = 0;
    while (req_ready !== onehot(id) && guard < 20) begin
      @(posedge clk); #2; guard++;
    end
    check({tag, "_accept"}, 32'(req_ready), 32'(onehot(id)));
    @(posedge clk); #1;
    pend[id] = 1'b0;
    apply_pins();
    check({tag, "_exec_novalid"}, 32'(rsp_valid), 32'(1'b0));
    @(posedge clk); #1;
    for (int k = 0; k <= hold; k++) begin
      check({tag, "_valid"}, 32'(rsp_valid), 32'(1'b1));
      check({tag, "_data"},  32'(rsp_data),  32'(exp));
      check({tag, "_id"},    32'(rsp_id),    32'(id));
      check({tag, "_zero"},  32'(rsp_zero),  32'(exp == 16'h0000));
      check({tag, "_noacc"}, 32'(req_ready), 32'(1'b0));
      rsp_ready = (k == hold);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    check({tag, "_done"}, 32'(rsp_valid), 32'(1'b0));
    m_cnt[id]++;
    m_ptr = (id + 1) % NREQ;
  endtask

  // cycle-by-cycle traffic checked against the transaction model
  task automatic run_cycles(input int n, input bit contend);
    logic [NREQ-1:0] exp_ready;
    int gid;
    for (int cyc = 0; cyc < n; cyc++) begin
      check("rnd_valid", 32'(rsp_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
        check("rnd_data", 32'(rsp_data), 32'(m_res));
        check("rnd_id",   32'(rsp_id),   32'(m_id));
        check("rnd_zero", 32'(rsp_zero), 32'(m_res == 16'h0000));
      end
      rsp_ready = contend ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          if (contend || $urandom_range(0, 2) == 0) begin
            pend[i] = 1'b1; p_op[i] = 3'($urandom); p_a[i] = 16'($urandom); p_b[i] = 16'($urandom);
          end
        end else if (!contend && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      apply_pins();
      #1;
      gid = -1;
      if (m_phase == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (gid < 0 && pend[(m_ptr + k) % NREQ]) gid = (m_ptr + k) % NREQ;
        end
      end
      exp_ready = (gid >= 0) ? onehot(gid) : '0;
      check("rnd_ready", 32'(req_ready), 32'(exp_ready));
      if (m_phase == 2) begin
        if (rsp_ready) begin
          m_phase = 0; m_cnt[m_id]++; m_ptr = (m_id + 1) % NREQ;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (gid >= 0) begin
        m_phase = 1; m_id = gid;
        m_res = ref_op(p_op[gid], p_a[gid], p_b[gid]);
        pend[gid] = 1'b0;
        acc_cyc.push_back(cyc); acc_id.push_back(gid);
      end
      @(posedge clk); #1;
    end
  endtask

  logic [W-1:0]        ops_exp [8];
  logic [16*NREQ-1:0]  exp_stat;

  initial begin
    ops_exp = '{16'h0000, 16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF, 16'h000F, 16'hF00F, 16'hF0F0};
    rst = 1'b1; rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; p_op[i] = 3'd0; p_a[i] = '0; p_b[i] = '0; m_cnt[i] = 0;
    end
    apply_pins();
    m_ptr = 0; m_phase = 0; m_id = 0; m_res = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(rsp_valid), 32'(1'b0));
    check("rst_data",  32'(rsp_data),  32'(16'h0000));
    check("rst_id",    32'(rsp_id),    32'(3'd0));
    check("rst_zero",  32'(rsp_zero),  32'(1'b1));
    check("rst_ready", 32'(req_ready), 32'(2'b00));
    check("rst_stat",  32'(stat_count), 32'(0));
    rst = 1'b0;

    do_op(0, 3'b000, 16'h00F8, 16'h1234, 16'hFF07, 0, "not");
    for (int op = 1; op < 8; op++) begin
      do_op(1, 3'(op), 16'hF0F0, 16'hFF00, ops_exp[op], 0, $sformatf("op%0d", op));
    end

    // back-pressure with a competing request held pending
    pend[1] = 1'b1; p_op[1] = 3'b001; p_a[1] = 16'h1111; p_b[1] = 16'h2222;
    do_op(0, 3'b000, 16'hFFFF, 16'h0000, 16'h0000, 5, "bp");
    pend[1] = 1'b0;
    apply_pins();

    // reset while the requester-1 transaction is in EXEC
    pend[1] = 1'b1; p_op[1] = 3'b010;
    apply_pins();
    #1;
    check("mid_accept", 32'(req_ready), 32'(onehot(1)));
    @(posedge clk); #1;
    pend[1] = 1'b0; apply_pins();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_valid", 32'(rsp_valid), 32'(1'b0));
    check("mid_zero",  32'(rsp_zero),  32'(1'b1));
    check("mid_stat",  32'(stat_count), 32'(0));
    m_ptr = 0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("mid_noresp", 32'(rsp_valid), 32'(1'b0));
    end
    pend[0] = 1'b1; pend[1] = 1'b1; apply_pins();
    #1;
    check("mid_ptr0", 32'(req_ready), 32'(onehot(0)));
    pend[0] = 1'b0; pend[1] = 1'b0; apply_pins();
    @(posedge clk); #1;

    for (int k = 0; k < 3; k++) do_op(0, 3'b011, 16'h00FF, 16'h0F0F, 16'h0FF0, 0, "st0");
    do_op(1, 3'b111, 16'hABCD, 16'h0000, 16'hABCD, 0, "st1");
`ifdef ALU_SCHED_STATS_EN
    exp_stat = {16'd1, 16'd3};
`else
    exp_stat = '0;
`endif
    check("stats_dir", 32'(stat_count), 32'(exp_stat));

    acc_cyc.delete(); acc_id.delete();
    run_cycles(14, 1'b1);
    check("cont_count", 32'(acc_id.size() >= 4), 32'(1'b1));
    if (acc_id.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        check("cont_id", 32'(acc_id[k]), 32'(k % 2));
        if (k > 0) check("cont_gap", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'(3));
      end
    end

    run_cycles(400, 1'b0);
`ifdef ALU_SCHED_STATS_EN
    for (int i = 0; i < NREQ; i++) exp_stat[16*i +: 16] = (m_cnt[i] > 65535) ? 16'hFFFF : 16'(m_cnt[i]);
`else
    exp_stat = '0;
`endif
    check("stats_rnd", 32'(stat_count), 32'(exp_stat));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
